// File: rtl/rescale_norm_pipe_if.sv
// Valid/ready handshake bundle for rescale_norm_pipe: input word side and normalised output side.
interface rescale_norm_pipe_if #(
  parameter int unsigned SCALE_W = 5,
  parameter int unsigned FRAC_W  = 12
);
  logic               in_valid;
  logic               in_ready;
  logic [SCALE_W-1:0] scale_in;
  logic [FRAC_W-1:0]  frac_in;
  logic               out_valid;
  logic               out_ready;
  logic [SCALE_W-1:0] scale_out;
  logic [FRAC_W-1:0]  frac_out;
  logic               zero_out;
  logic               ovf_out;
  logic               unf_out;

  modport master (
    output in_valid, scale_in, frac_in, out_ready,
    input  in_ready, out_valid, scale_out, frac_out, zero_out, ovf_out, unf_out
  );

  modport slave (
    input  in_valid, scale_in, frac_in, out_ready,
    output in_ready, out_valid, scale_out, frac_out, zero_out, ovf_out, unf_out
  );
endinterface

// File: rtl/rescale_norm_pipe.sv
// Two-stage leading-one normaliser for <2.F> fraction / signed scale words, with saturation.
// Define RESCALE_NORM_ROUND_EN for round-to-nearest-even on the right-shift case.
module rescale_norm_pipe #(
  parameter int unsigned SCALE_W = 5,
  parameter int unsigned FRAC_W  = 12
) (
  input  logic               clk,
  input  logic               rst,
  rescale_norm_pipe_if.slave bus
);

  localparam int unsigned XW   = SCALE_W + 2;
  localparam int unsigned SH_W = $clog2(FRAC_W);
  localparam logic signed [XW-1:0] ScaleMax = XW'((1 << (SCALE_W - 1)) - 1);
  localparam logic signed [XW-1:0] ScaleMin = XW'(-(1 << (SCALE_W - 1)));

  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv;

  assign s2_adv      = !s2_valid_q || bus.out_ready;
  assign s1_adv      = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  // Stage 1: leading-one search and extended-width candidate scale.
  logic [SH_W-1:0]        lead_pos;
  logic [SH_W-1:0]        lshift_in;
  logic                   right_in, zero_in;
  logic signed [XW-1:0]   scale_ext, cand_in;

  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < FRAC_W; i++) begin
      if (bus.frac_in[i]) lead_pos = SH_W'(i);
    end
  end

  always_comb begin
    right_in  = bus.frac_in[FRAC_W-1];
    zero_in   = (bus.frac_in == '0);
    scale_ext = {{2{bus.scale_in[SCALE_W-1]}}, bus.scale_in};
    lshift_in = '0;
    if (right_in) begin
      cand_in = scale_ext + XW'(1);
    end else begin
      lshift_in = SH_W'(FRAC_W - 2) - lead_pos;
      cand_in   = scale_ext - XW'(lshift_in);
    end
  end

  logic [FRAC_W-1:0]    s1_frac_q;
  logic [SH_W-1:0]      s1_shift_q;
  logic signed [XW-1:0] s1_scale_q;
  logic                 s1_right_q, s1_zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_frac_q  <= '0;
      s1_shift_q <= '0;
      s1_scale_q <= '0;
      s1_right_q <= 1'b0;
      s1_zero_q  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_frac_q  <= bus.frac_in;
        s1_shift_q <= lshift_in;
        s1_scale_q <= cand_in;
        s1_right_q <= right_in;
        s1_zero_q  <= zero_in;
      end
    end
  end

  // Stage 2: shift, optional rounding, then range check on the final scale.
  logic [FRAC_W-1:0]    frac_d;
  logic signed [XW-1:0] scale_x;
  logic                 zero_d, ovf_d, unf_d;

  always_comb begin
    frac_d  = '0;
    scale_x = s1_scale_q;
    zero_d  = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (s1_right_q) begin
      frac_d = s1_frac_q >> 1;
`ifdef RESCALE_NORM_ROUND_EN
      // Dropped bit is always exactly one half, so only the kept LSB decides.
      if (s1_frac_q[0] && s1_frac_q[1]) begin
        frac_d = frac_d + FRAC_W'(1);
        if (frac_d[FRAC_W-1]) begin
          frac_d  = {2'b01, {(FRAC_W - 2){1'b0}}};
          scale_x = s1_scale_q + XW'(1);
        end
      end
`endif
    end else begin
      frac_d = s1_frac_q << s1_shift_q;
    end

    if (s1_zero_q) begin
      frac_d  = '0;
      scale_x = ScaleMin;
      zero_d  = 1'b1;
    end else if (scale_x > ScaleMax) begin
      frac_d  = {1'b0, {(FRAC_W - 1){1'b1}}};
      scale_x = ScaleMax;
      ovf_d   = 1'b1;
    end else if (scale_x < ScaleMin) begin
      frac_d  = '0;
      scale_x = ScaleMin;
      zero_d  = 1'b1;
      unf_d   = 1'b1;
    end
  end

  logic [FRAC_W-1:0]  s2_frac_q;
  logic [SCALE_W-1:0] s2_scale_q;
  logic               s2_zero_q, s2_ovf_q, s2_unf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_frac_q  <= '0;
      s2_scale_q <= '0;
      s2_zero_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_unf_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_frac_q  <= frac_d;
        s2_scale_q <= scale_x[SCALE_W-1:0];
        s2_zero_q  <= zero_d;
        s2_ovf_q   <= ovf_d;
        s2_unf_q   <= unf_d;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.frac_out  = s2_frac_q;
  assign bus.scale_out = s2_scale_q;
  assign bus.zero_out  = s2_zero_q;
  assign bus.ovf_out   = s2_ovf_q;
  assign bus.unf_out   = s2_unf_q;

endmodule

// File: tb/tb_rescale_norm_pipe.sv
// Bench for rescale_norm_pipe: directed vectors with literal expectations plus a scoreboard model.
module tb_rescale_norm_pipe;
  localparam int SW = 5;
  localparam int FW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rescale_norm_pipe_if #(.SCALE_W(SW), .FRAC_W(FW)) bus ();
  rescale_norm_pipe #(.SCALE_W(SW), .FRAC_W(FW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [FW-1:0] frac;
    logic [SW-1:0] scale;
    logic          zero;
    logic          ovf;
    logic          unf;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  bit   lat_check = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: value-preserving renormalisation by repeated doubling, then range check.
  function automatic exp_t model(input logic [FW-1:0] f, input logic [SW-1:0] s, input int c);
    exp_t r;
    int v, e, lo, hi;
`ifdef RESCALE_NORM_ROUND_EN
    int d;
`endif
    r     = '0;
    r.cyc = c;
    lo    = -(1 << (SW - 1));
    hi    = (1 << (SW - 1)) - 1;
    v     = int'(f);
    e     = int'($signed(s));
    if (v == 0) begin
      r.scale = SW'(lo);
      r.zero  = 1'b1;
      return r;
    end
    if (v >= (1 << (FW - 1))) begin
`ifdef RESCALE_NORM_ROUND_EN
      d = v % 2;
`endif
      v = v / 2;
      e = e + 1;
`ifdef RESCALE_NORM_ROUND_EN
      if (d == 1 && v % 2 == 1) v = v + 1;
      if (v == (1 << (FW - 1))) begin
        v = v / 2;
        e = e + 1;
      end
`endif
    end
    while (v < (1 << (FW - 2))) begin
      v = v * 2;
      e = e - 1;
    end
    if (e > hi) begin
      r.ovf = 1'b1; r.scale = SW'(hi); r.frac = FW'((1 << (FW - 1)) - 1);
    end else if (e < lo) begin
      r.unf = 1'b1; r.zero = 1'b1; r.scale = SW'(lo); r.frac = '0;
    end else begin
      r.frac = FW'(v); r.scale = SW'(e);
    end
    return r;
  endfunction

  logic [FW-1:0] h_frac;
  logic [SW-1:0] h_scale;
  logic [2:0]    h_flags;
  bit            held = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("hold_frac", {20'b0, bus.frac_out}, {20'b0, h_frac});
        chk("hold_scale", {27'b0, bus.scale_out}, {27'b0, h_scale});
        chk("hold_flags", {29'b0, bus.zero_out, bus.ovf_out, bus.unf_out}, {29'b0, h_flags});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_output", sb.size(), 32'd1);
        end else begin
          got_e = sb.pop_front();
          chk("sb_frac", {20'b0, bus.frac_out}, {20'b0, got_e.frac});
          chk("sb_scale", {27'b0, bus.scale_out}, {27'b0, got_e.scale});
          chk("sb_flags", {29'b0, bus.zero_out, bus.ovf_out, bus.unf_out},
              {29'b0, got_e.zero, got_e.ovf, got_e.unf});
          if (lat_check) chk("sb_latency", cyc - got_e.cyc, 32'd2);
        end
      end
      held = bus.out_valid && !bus.out_ready;
      if (held) begin
        h_frac  = bus.frac_out;
        h_scale = bus.scale_out;
        h_flags = {bus.zero_out, bus.ovf_out, bus.unf_out};
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.frac_in, bus.scale_in, cyc));
    end
  end

  // One word with OUT_READY high; result must be visible two cycles after it is presented.
  task automatic direct(input string name, input logic [FW-1:0] f, input logic [SW-1:0] s,
                        input logic [FW-1:0] ef, input logic [SW-1:0] es, input logic [2:0] efl);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.frac_in = f; bus.scale_in = s;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk({name, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
    chk({name, "_frac"}, {20'b0, bus.frac_out}, {20'b0, ef});
    chk({name, "_scale"}, {27'b0, bus.scale_out}, {27'b0, es});
    chk({name, "_flags"}, {29'b0, bus.zero_out, bus.ovf_out, bus.unf_out}, {29'b0, efl});
  endtask

  logic [FW-1:0] bp_f [6] = '{12'h800, 12'h001, 12'hC03, 12'h5A3, 12'h003, 12'hFFF};
  logic [SW-1:0] bp_s [6] = '{5'd3, 5'd0, 5'd0, 5'd2, 5'h18, 5'd0};
  int sent;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.frac_in = '0; bus.scale_in = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_frac", {20'b0, bus.frac_out}, 32'd0);
    chk("rst_scale", {27'b0, bus.scale_out}, 32'd0);
    chk("rst_flags", {29'b0, bus.zero_out, bus.ovf_out, bus.unf_out}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    rst = 1'b0;

    // flags are {zero, ovf, unf}
    direct("right_shift", 12'h800, 5'd3, 12'h400, 5'd4, 3'b000);
    direct("left_shift10", 12'h001, 5'd0, 12'h400, 5'h16, 3'b000);
    direct("pass_through", 12'h5A3, 5'd2, 12'h5A3, 5'd2, 3'b000);
    direct("overflow", 12'hC01, 5'd15, 12'h7FF, 5'd15, 3'b010);
    direct("underflow", 12'h003, 5'h18, 12'h000, 5'h10, 3'b101);
    direct("zero_in", 12'h000, 5'd5, 12'h000, 5'h10, 3'b100);
    direct("rnd_even_down", 12'hC01, 5'd0, 12'h600, 5'd1, 3'b000);
`ifdef RESCALE_NORM_ROUND_EN
    direct("rnd_tie_up", 12'hC03, 5'd0, 12'h602, 5'd1, 3'b000);
    direct("rnd_carry", 12'hFFF, 5'd0, 12'h400, 5'd2, 3'b000);
`else
    direct("trunc_c03", 12'hC03, 5'd0, 12'h601, 5'd1, 3'b000);
    direct("trunc_fff", 12'hFFF, 5'd0, 12'h7FF, 5'd1, 3'b000);
`endif

    // Backpressure: OUT_READY low for cycles 2..5 of the stream.
    lat_check = 1'b0;
    sent = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      bus.out_ready = !(k >= 2 && k <= 5);
      bus.in_valid  = (sent < 6);
      if (sent < 6) begin
        bus.frac_in  = bp_f[sent];
        bus.scale_in = bp_s[sent];
      end
      #1;
      if (k == 1) chk("bp_ready_open", {31'b0, bus.in_ready}, 32'd1);
      if (k == 2) chk("bp_ready_low", {31'b0, bus.in_ready}, 32'd0);
      if (k == 5) chk("bp_ready_still_low", {31'b0, bus.in_ready}, 32'd0);
      if (k == 6) chk("bp_ready_resume", {31'b0, bus.in_ready}, 32'd1);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("bp_sent", sent, 32'd6);
    chk("bp_drained", sb.size(), 32'd0);
    @(posedge clk); #1;
    lat_check = 1'b1;

    // Continuous stream of 20 words.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.frac_in  = (i % 5 == 0) ? FW'(1 << (i % 12)) : FW'((i * 613 + 37) % 4096);
      bus.scale_in = SW'((i * 7) % 32);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stream_drained", sb.size(), 32'd0);

    // Reset with two words in flight.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.frac_in = 12'h123; bus.scale_in = 5'd1;
    @(posedge clk); #1;
    bus.frac_in = 12'h9AB; bus.scale_in = 5'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mid_rst_frac", {20'b0, bus.frac_out}, 32'd0);
    chk("mid_rst_scale", {27'b0, bus.scale_out}, 32'd0);
    chk("mid_rst_flags", {29'b0, bus.zero_out, bus.ovf_out, bus.unf_out}, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_empty", {31'b0, bus.out_valid}, 32'd0);
    direct("post_rst", 12'h800, 5'd3, 12'h400, 5'd4, 3'b000);

    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
